// File: rtl/pong_game_ctrl.sv
// Game sequencer for the bouncing-ball datapath: serve hold, play with
// paddle hit/miss detection, post-miss freeze, and game-over. Drives the
// ball block's reset/animate and keeps a saturating score and a lives count.
module pong_game_ctrl #(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned MISS_FRAMES  = 30,
    parameter int unsigned PAD_Y        = 460,
    parameter int unsigned MISS_Y       = 478,
    parameter int unsigned SCORE_W      = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ani_stb,
    input  logic               i_start,
    input  logic [11:0]        i_ball_x1,
    input  logic [11:0]        i_ball_x2,
    input  logic [11:0]        i_ball_y2,
    input  logic [11:0]        i_pad_x1,
    input  logic [11:0]        i_pad_x2,
    output logic               o_ball_rst,
    output logic               o_animate,
    output logic [SCORE_W-1:0] o_score,
    output logic [1:0]         o_lives,
    output logic [2:0]         o_state,
    output logic               o_game_over
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StPlay  = 3'd2,
        StMiss  = 3'd3,
        StOver  = 3'd4
    } state_e;

    localparam logic [7:0]  ServeLast = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]  MissLast  = 8'(MISS_FRAMES - 1);
    localparam logic [11:0] PadY      = 12'(PAD_Y);
    localparam logic [11:0] MissY     = 12'(MISS_Y);
    localparam logic [1:0]  LivesInit = 2'(LIVES);

    state_e               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [1:0]           lives_q, lives_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 latch_q, latch_d;
    logic                 start_q;

    logic start_rise;
    logic in_band;
    logic missed;
    logic overlap;

    assign start_rise = i_start & ~start_q;
    assign in_band    = (i_ball_y2 >= PadY);
    assign missed     = (i_ball_y2 >= MissY);
    assign overlap    = (i_ball_x2 >= i_pad_x1) && (i_ball_x1 <= i_pad_x2);

    // Next-state and datapath updates for the game sequence.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        latch_d = latch_q;

        case (state_q)
            StIdle, StOver: begin
                // Strobe is ignored here; only a fresh press starts a game.
                if (start_rise) begin
                    state_d = StServe;
                    score_d = '0;
                    lives_d = LivesInit;
                    cnt_d   = '0;
                end
            end
            StServe: begin
                if (i_ani_stb) begin
                    if (cnt_q == ServeLast) begin
                        state_d = StPlay;
                        cnt_d   = '0;
                        latch_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StPlay: begin
                if (i_ani_stb) begin
                    if (missed) begin
                        // A miss outranks any paddle overlap on the same frame.
                        lives_d = lives_q - 2'd1;
                        cnt_d   = '0;
                        state_d = (lives_q == 2'd1) ? StOver : StMiss;
                    end else if (in_band) begin
                        if (overlap && !latch_q) begin
                            if (score_q != {SCORE_W{1'b1}}) begin
                                score_d = score_q + 1'b1;
                            end
                            latch_d = 1'b1;
                        end
                    end else begin
                        latch_d = 1'b0;
                    end
                end
            end
            StMiss: begin
                if (i_ani_stb) begin
                    if (cnt_q == MissLast) begin
                        state_d = StServe;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            score_q <= '0;
            lives_q <= '0;
            cnt_q   <= '0;
            latch_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            start_q <= i_start;
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        o_ball_rst  = 1'b1;
        o_animate   = 1'b0;
        o_game_over = 1'b0;
        case (state_q)
            StIdle, StServe: o_ball_rst = 1'b1;
            StPlay: begin
                o_ball_rst = 1'b0;
                o_animate  = 1'b1;
            end
            StMiss: o_ball_rst = 1'b0;
            StOver: begin
                o_ball_rst  = 1'b0;
                o_game_over = 1'b1;
            end
            default: o_ball_rst = 1'b1;
        endcase
    end

    assign o_state = state_q;
    assign o_score = score_q;
    assign o_lives = lives_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a frame-level game model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_pong_game_ctrl;

    localparam int SCORE_MAX = 255;
    localparam int N_LIVES   = 3;
    localparam int N_SERVE   = 60;
    localparam int N_MISS    = 30;
    localparam int Y_PAD     = 460;
    localparam int Y_MISS    = 478;

    logic        clk;
    logic        rst_n;
    logic        ani_stb;
    logic        start;
    logic [11:0] ball_x1, ball_x2, ball_y2, pad_x1, pad_x2;
    logic        ball_rst, animate, game_over;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic [2:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    pong_game_ctrl #(
        .LIVES       (N_LIVES),
        .SERVE_FRAMES(N_SERVE),
        .MISS_FRAMES (N_MISS),
        .PAD_Y       (Y_PAD),
        .MISS_Y      (Y_MISS),
        .SCORE_W     (8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_ani_stb  (ani_stb),
        .i_start    (start),
        .i_ball_x1  (ball_x1),
        .i_ball_x2  (ball_x2),
        .i_ball_y2  (ball_y2),
        .i_pad_x1   (pad_x1),
        .i_pad_x2   (pad_x2),
        .o_ball_rst (ball_rst),
        .o_animate  (animate),
        .o_score    (score),
        .o_lives    (lives),
        .o_state    (state),
        .o_game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Game model: 0 idle, 1 serve, 2 play, 3 miss, 4 over.
    int m_state, m_score, m_lives, m_cnt;
    bit m_latch, m_start_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0; m_score <= 0; m_lives <= 0; m_cnt <= 0;
            m_latch <= 0; m_start_q <= 0;
        end else begin
            m_start_q <= start;
            if (m_state == 0 || m_state == 4) begin
                if (start && !m_start_q) begin
                    m_state <= 1; m_score <= 0; m_lives <= N_LIVES; m_cnt <= 0;
                end
            end else if (m_state == 1 && ani_stb) begin
                if (m_cnt == N_SERVE - 1) begin
                    m_state <= 2; m_cnt <= 0; m_latch <= 0;
                end else m_cnt <= m_cnt + 1;
            end else if (m_state == 3 && ani_stb) begin
                if (m_cnt == N_MISS - 1) begin
                    m_state <= 1; m_cnt <= 0;
                end else m_cnt <= m_cnt + 1;
            end else if (m_state == 2 && ani_stb) begin
                if (int'(ball_y2) >= Y_MISS) begin
                    m_lives <= m_lives - 1;
                    m_cnt   <= 0;
                    m_state <= (m_lives == 1) ? 4 : 3;
                end else if (int'(ball_y2) >= Y_PAD) begin
                    if (ball_x2 >= pad_x1 && ball_x1 <= pad_x2 && !m_latch) begin
                        if (m_score < SCORE_MAX) m_score <= m_score + 1;
                        m_latch <= 1;
                    end
                end else m_latch <= 0;
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        check("state", int'(state), m_state);
        check("score", int'(score), m_score);
        check("lives", int'(lives), m_lives);
        check("ball_rst", int'(ball_rst), (m_state <= 1) ? 1 : 0);
        check("animate", int'(animate), (m_state == 2) ? 1 : 0);
        check("game_over", int'(game_over), (m_state == 4) ? 1 : 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One animation frame: a single-cycle strobe then two idle cycles.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            ani_stb = 1'b1;
            tick();
            ani_stb = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic press();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic miss_frame();
        ball_y2 = 12'd478;
        frames(1);
        ball_y2 = 12'd100;
    endtask

    initial begin
        rst_n   = 1'b0;
        ani_stb = 1'b0;
        start   = 1'b0;
        ball_x1 = 12'd300; ball_x2 = 12'd320; ball_y2 = 12'd100;
        pad_x1  = 12'd310; pad_x2  = 12'd370;
        tick();
        check("rst_state", int'(state), 0);
        check("rst_ball_rst", int'(ball_rst), 1);
        check("rst_lives", int'(lives), 0);
        tick();
        rst_n = 1'b1;
        frames(2);
        check("idle_ignores_stb", int'(state), 0);

        // 1: start, serve hold, play
        press();
        check("t1_serve", int'(state), 1);
        check("t1_lives", int'(lives), 3);
        check("t1_score", int'(score), 0);
        frames(N_SERVE - 1);
        check("t1_still_serve", int'(state), 1);
        frames(1);
        check("t1_play", int'(state), 2);
        check("t1_animate", int'(animate), 1);
        check("t1_ball_rst", int'(ball_rst), 0);

        // 2: one point per contact
        ball_y2 = 12'd465;
        frames(5);
        check("t2_one_point", int'(score), 1);
        ball_y2 = 12'd400;
        frames(1);
        ball_y2 = 12'd465;
        frames(1);
        check("t2_second_point", int'(score), 2);
        ball_y2 = 12'd100;
        frames(1);
        pad_x1 = 12'd321;   // one past ball right edge: no overlap
        ball_y2 = 12'd465;
        frames(1);
        check("t2_no_overlap", int'(score), 2);
        pad_x1 = 12'd320;   // touching edge counts
        frames(1);
        check("t2_edge_overlap", int'(score), 3);
        pad_x1 = 12'd310;
        ball_y2 = 12'd100;
        frames(1);

        // 3: miss wins over overlap
        miss_frame();
        check("t3_miss_state", int'(state), 3);
        check("t3_lives", int'(lives), 2);
        check("t3_score_held", int'(score), 3);
        check("t3_animate", int'(animate), 0);
        press();
        check("t3_start_ignored", int'(state), 3);
        frames(N_MISS - 1);
        check("t3_still_miss", int'(state), 3);
        frames(1);
        check("t3_serve", int'(state), 1);
        frames(N_SERVE);

        // Finish this game, then three misses from a fresh game.
        miss_frame(); frames(N_MISS); frames(N_SERVE);
        miss_frame();
        check("t4a_over", int'(state), 4);
        press();
        frames(N_SERVE);
        miss_frame(); frames(N_MISS); frames(N_SERVE);
        miss_frame(); frames(N_MISS); frames(N_SERVE);
        start = 1'b1;        // rise lands in PLAY and is ignored
        tick();
        miss_frame();
        check("t4_over", int'(state), 4);
        check("t4_game_over", int'(game_over), 1);
        check("t4_lives", int'(lives), 0);
        frames(3);
        check("t4_held_no_restart", int'(state), 4);
        start = 1'b0;
        tick();
        start = 1'b1;        // press together with a strobe: strobe ignored
        ani_stb = 1'b1;
        tick();
        start = 1'b0;
        ani_stb = 1'b0;
        tick();
        check("t4_restart", int'(state), 1);
        check("t4_lives3", int'(lives), 3);
        check("t4_score0", int'(score), 0);
        frames(N_SERVE);
        check("t4_play", int'(state), 2);

        // 5: saturation
        for (int i = 0; i < 256; i++) begin
            ball_y2 = 12'd465;
            frames(1);
            ball_y2 = 12'd400;
            frames(1);
        end
        check("t5_saturate", int'(score), 255);

        // 6: asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_state", int'(state), 0);
        check("t6_animate", int'(animate), 0);
        check("t6_ball_rst", int'(ball_rst), 1);
        check("t6_score", int'(score), 0);
        tick();
        rst_n = 1'b1;
        frames(2);
        check("t6_wait_start", int'(state), 0);
        press();
        check("t6_serve", int'(state), 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
